instruction_fetch_unit: RTL and testbench

- Reader side of the instruction memory interface. Drives `address` and `programSelect` into the combinational instruction ROM and captures the returned 16-bit word.
- Presents each word to the decode/execute stage over a valid/ready handshake.
- Stops on the HALT opcode (4'b1110) or on running off the end of the program space.
- Sits between the instruction ROM and the CPU decoder; it is the only block that sequences the program counter.

---
 rtl/instruction_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - program counter sequencer and valid/ready instruction presenter
// Optional single-step mode: define FETCH_SINGLE_STEP_EN to add stepEn/stepReq and STEP_WAIT.
module instruction_fetch_unit #(
    parameter int         ADDR_WIDTH  = 8,
    parameter int         INSTR_WIDTH = 16,
    parameter int         PROG_DEPTH  = 128,
    parameter logic [3:0] HALT_OPCODE = 4'b1110
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             programSelectIn,
    output logic [1:0]             programSelect,
    output logic [ADDR_WIDTH-1:0]  address,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic [INSTR_WIDTH-1:0] instrOut,
    output logic                   instrValid,
    input  logic                   instrReady,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic                   busy,
    output logic                   halted,
    output logic                   overrun
`ifdef FETCH_SINGLE_STEP_EN
    ,
    input  logic                   stepEn,
    input  logic                   stepReq
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRESENT,
        ST_HALT
`ifdef FETCH_SINGLE_STEP_EN
        ,
        ST_STEP_WAIT
`endif
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(PROG_DEPTH - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [1:0]              psel_q, psel_d;
    logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    is_halt_word;

    assign is_halt_word = (instr_q[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            psel_q    <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            psel_q    <= psel_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        psel_d    = psel_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    psel_d    = programSelectIn;
                    pc_d      = '0;
                    overrun_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                instr_d = instruction;
                valid_d = 1'b1;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (instrReady) begin
                    valid_d = 1'b0;
                    if (is_halt_word) begin
                        state_d = ST_HALT;
                    end else if (pc_q == LAST_PC) begin
                        // Ran off the end of program space: stop without wrapping.
                        overrun_d = 1'b1;
                        state_d   = ST_HALT;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = ST_FETCH;
`ifdef FETCH_SINGLE_STEP_EN
                        if (stepEn) state_d = ST_STEP_WAIT;
`endif
                    end
                end
            end
`ifdef FETCH_SINGLE_STEP_EN
            ST_STEP_WAIT: begin
                if (stepReq) state_d = ST_FETCH;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign programSelect = psel_q;
    assign address       = pc_q;
    assign pc            = pc_q;
    assign instrOut      = instr_q;
    assign instrValid    = valid_q;
    assign overrun       = overrun_q;
    assign halted        = (state_q == ST_HALT);
`ifdef FETCH_SINGLE_STEP_EN
    assign busy = (state_q == ST_FETCH) || (state_q == ST_PRESENT) || (state_q == ST_STEP_WAIT);
`else
    assign busy = (state_q == ST_FETCH) || (state_q == ST_PRESENT);
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  programSelectIn;
    logic [1:0]  programSelect;
    logic [7:0]  address;
    logic [15:0] instruction;
    logic [15:0] instrOut;
    logic        instrValid;
    logic        instrReady;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        overrun;
`ifdef FETCH_SINGLE_STEP_EN
    logic        stepEn;
    logic        stepReq;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .programSelectIn (programSelectIn),
        .programSelect   (programSelect),
        .address         (address),
        .instruction     (instruction),
        .instrOut        (instrOut),
        .instrValid      (instrValid),
        .instrReady      (instrReady),
        .pc              (pc),
        .busy            (busy),
        .halted          (halted),
        .overrun         (overrun)
`ifdef FETCH_SINGLE_STEP_EN
        ,
        .stepEn          (stepEn),
        .stepReq         (stepReq)
`endif
    );

    function automatic logic [15:0] rom(input logic [1:0] ps, input logic [7:0] a);
        logic [15:0] w;
        w = 16'hE000;
        case (ps)
            2'b00: w = 16'h2001;
            2'b10: case (a)
                8'd0: w = 16'h0102;
                8'd1: w = 16'h2F10;
                8'd2: w = 16'h0203;
                8'd3: w = 16'h2F20;
                8'd4: w = 16'h4F21;
                default: w = 16'hE000;
            endcase
            2'b11: case (a)
                8'd0: w = 16'h1000;
                8'd1: w = 16'h1001;
                8'd2: w = 16'h1002;
                8'd3: w = 16'h6412;
                8'd4: w = 16'h7512;
                8'd5: w = 16'h2003;
                8'd6: w = 16'h2004;
                8'd7: w = 16'h2005;
                8'd8: w = 16'h2006;
                default: w = 16'hE000;
            endcase
            default: w = 16'hE000;
        endcase
        return w;
    endfunction

    always_comb instruction = rom(programSelect, address);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] ps);
        programSelectIn = ps;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) for a presented word, then checks it.
    task automatic expect_word(input string tag, input logic [15:0] w, input logic [7:0] p);
        int n = 0;
        while (!instrValid && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(instrValid), 32'd1);
        check({tag, "_instr"}, 32'(instrOut), 32'(w));
        check({tag, "_pc"}, 32'(pc), 32'(p));
    endtask

    task automatic accept(input string tag);
        tick();
        check({tag, "_pulse1"}, 32'(instrValid), 32'd0);
    endtask

    logic [15:0] prog10 [6];
    logic [15:0] prog11 [10];

    initial begin
        prog10 = '{16'h0102, 16'h2F10, 16'h0203, 16'h2F20, 16'h4F21, 16'hE000};
        prog11 = '{16'h1000, 16'h1001, 16'h1002, 16'h6412, 16'h7512,
                   16'h2003, 16'h2004, 16'h2005, 16'h2006, 16'hE000};
        rst_n = 1'b0;
        start = 1'b0;
        programSelectIn = 2'b00;
        instrReady = 1'b1;
`ifdef FETCH_SINGLE_STEP_EN
        stepEn  = 1'b0;
        stepReq = 1'b0;
`endif
        tick();
        tick();
        check("rst_outs", {programSelect, address, pc, instrOut, instrValid, busy, halted, overrun},
              32'd0);
        check("rst_instrOut", 32'(instrOut), 32'd0);
        rst_n = 1'b1;
        tick();

        // Program 2'b10, ready held high: latency and 2-cycle spacing.
        pulse_start(2'b10);
        check("lat_fetch_valid", 32'(instrValid), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        tick();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("p10_%0d_valid", i), 32'(instrValid), 32'd1);
            check($sformatf("p10_%0d_instr", i), 32'(instrOut), 32'(prog10[i]));
            check($sformatf("p10_%0d_pc", i), 32'(pc), 32'(i));
            tick();
            check($sformatf("p10_%0d_gap", i), 32'(instrValid), 32'd0);
            if (i < 5) tick();
        end
        check("p10_halted", 32'(halted), 32'd1);
        check("p10_pc", 32'(pc), 32'd5);
        check("p10_overrun", 32'(overrun), 32'd0);
        check("p10_busy", 32'(busy), 32'd0);

        // Program 2'b11 with backpressure on word 3.
        pulse_start(2'b11);
        for (int i = 0; i < 3; i++) begin
            expect_word($sformatf("p11_%0d", i), prog11[i], 8'(i));
            accept("p11");
        end
        expect_word("p11_3", 16'h6412, 8'd3);
        instrReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 32'(instrValid), 32'd1);
            check("stall_instr", 32'(instrOut), 32'h6412);
            check("stall_pc", 32'(pc), 32'd3);
        end
        instrReady = 1'b1;
        accept("p11_3");
        for (int i = 4; i < 10; i++) begin
            expect_word($sformatf("p11_%0d", i), prog11[i], 8'(i));
            accept("p11");
        end
        check("p11_halted", 32'(halted), 32'd1);
        check("p11_pc", 32'(pc), 32'd9);

        // No HALT in program space: overrun at the last address.
        pulse_start(2'b00);
        for (int i = 0; i < 128; i++) begin
            expect_word("ovr", 16'h2001, 8'(i));
            tick();
        end
        check("ovr_overrun", 32'(overrun), 32'd1);
        check("ovr_halted", 32'(halted), 32'd1);
        check("ovr_pc", 32'(pc), 32'd127);
        tick();
        check("ovr_hold_pc", 32'(pc), 32'd127);
        pulse_start(2'b00);
        check("restart_overrun", 32'(overrun), 32'd0);
        check("restart_pc", 32'(pc), 32'd0);
        check("restart_halted", 32'(halted), 32'd0);
        expect_word("restart_w0", 16'h2001, 8'd0);
        instrReady = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        instrReady = 1'b1;

        // start during PRESENT and FETCH is ignored.
        pulse_start(2'b10);
        expect_word("ign_0", prog10[0], 8'd0);
        accept("ign_0");
        expect_word("ign_1", prog10[1], 8'd1);
        pulse_start(2'b11);
        check("ign_psel_present", 32'(programSelect), 32'd2);
        check("ign_fetch_valid", 32'(instrValid), 32'd0);
        pulse_start(2'b11);
        check("ign_psel_fetch", 32'(programSelect), 32'd2);
        for (int i = 2; i < 6; i++) begin
            expect_word($sformatf("ign_%0d", i), prog10[i], 8'(i));
            accept("ign");
        end
        check("ign_halted", 32'(halted), 32'd1);

        // Asynchronous reset mid-PRESENT at pc=2.
        pulse_start(2'b10);
        expect_word("ar_0", prog10[0], 8'd0);
        accept("ar_0");
        expect_word("ar_1", prog10[1], 8'd1);
        accept("ar_1");
        expect_word("ar_2", prog10[2], 8'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_outs", {programSelect, address, pc, instrValid, busy, halted, overrun}, 32'd0);
        check("ar_instrOut", 32'(instrOut), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ar_idle", {29'd0, instrValid, busy, halted}, 32'd0);
        end

`ifdef FETCH_SINGLE_STEP_EN
        stepEn = 1'b1;
        pulse_start(2'b10);
        expect_word("st_0", prog10[0], 8'd0);
        accept("st_0");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_wait", {28'd0, busy, instrValid, 2'b00}, 32'b1000);
            check("st_wait_pc", 32'(pc), 32'd1);
        end
        stepReq = 1'b1;
        tick();
        stepReq = 1'b0;
        check("st_fetch_valid", 32'(instrValid), 32'd0);
        tick();
        check("st_present_valid", 32'(instrValid), 32'd1);
        check("st_present_instr", 32'(instrOut), 32'h2F10);
        stepEn = 1'b0;
        accept("st_1");
        for (int i = 2; i < 6; i++) begin
            expect_word($sformatf("st_%0d", i), prog10[i], 8'(i));
            accept("st");
        end
        check("st_halted", 32'(halted), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
